// File: rtl/dram_model.sv
// Cycle-accurate single-bank DRAM behind the AXI wrapper: decodes CSn/RASn/CASn/WEn
// commands, enforces tRP/tRCD/CL timing and flags protocol violations on cmd_err.
module dram_model #(
  parameter int unsigned ROW_BITS = 11,
  parameter int unsigned COL_BITS = 10,
  parameter int unsigned T_RP     = 5,
  parameter int unsigned T_RCD    = 5,
  parameter int unsigned T_CL     = 5
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                CSn,
  input  logic                RASn,
  input  logic                CASn,
  input  logic [3:0]          WEn,
  input  logic [ROW_BITS-1:0] A,
  input  logic [31:0]         D,
  output logic [31:0]         Q,
  output logic                valid,
  output logic                row_open,
  output logic                cmd_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ADDR_W = ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned T_MAX  = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int unsigned CNT_W  = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACTIVATING  = 2'd1,
    ACTIVE      = 2'd2,
    PRECHARGING = 2'd3
  } state_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] dat;
  } rd_slot_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                err_d;
  logic                rd_go, wr_go;
  logic                sel, is_act, is_pre, is_rd, is_wr, is_bad;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   mem [DEPTH];
  rd_slot_t            pipe_q [T_CL];
  rd_slot_t            new_slot;

  // Command decode; any selected encoding outside the four commands is illegal
  assign sel    = !CSn;
  assign is_act = sel && !RASn &&  CASn && (WEn == 4'hF);
  assign is_pre = sel && !RASn &&  CASn && (WEn == 4'h0);
  assign is_rd  = sel &&  RASn && !CASn && (WEn == 4'hF);
  assign is_wr  = sel &&  RASn && !CASn && (WEn != 4'hF);
  assign is_bad = sel && !(is_act || is_pre || is_rd || is_wr);

  assign addr = {row_q, A[COL_BITS-1:0]};

  // Bank state machine: next state, timing counter, open row and error flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    err_d   = cmd_err;
    rd_go   = 1'b0;
    wr_go   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_act) begin
          row_d = A;
          if (T_RCD <= 1) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            state_d = ACTIVATING;
            cnt_d   = CNT_W'(T_RCD - 1);
          end
        end else if (is_rd || is_wr) begin
          err_d = 1'b1;
        end
      end
      ACTIVATING: begin
        // Leave as the counter reaches zero so a command tRCD after ACT is legal
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (sel) err_d = 1'b1;
      end
      ACTIVE: begin
        rd_go = is_rd;
        wr_go = is_wr;
        if (is_pre) begin
          if (T_RP <= 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = PRECHARGING;
            cnt_d   = CNT_W'(T_RP - 1);
          end
        end
        if (is_act) err_d = 1'b1;
      end
      PRECHARGING: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (sel) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (is_bad) err_d = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      cmd_err  <= 1'b0;
      row_open <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      cmd_err  <= err_d;
      row_open <= (state_d == ACTIVE);
    end
  end

  // Storage array is deliberately not reset; byte lanes written where WEn is low
  always_ff @(posedge ACLK) begin
    if (wr_go) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (!WEn[i]) mem[addr][8*i +: 8] <= D[8*i +: 8];
      end
    end
  end

  always_comb begin
    new_slot.vld = rd_go;
    new_slot.dat = mem[addr];
  end

  // CAS-latency pipeline: data snapshotted at the READ edge, Q updates only on valid
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int unsigned i = 0; i < T_CL; i++) pipe_q[i] <= '0;
      valid <= 1'b0;
      Q     <= '0;
    end else begin
      pipe_q[0] <= new_slot;
      for (int unsigned i = 1; i < T_CL; i++) pipe_q[i] <= pipe_q[i-1];
      valid <= pipe_q[T_CL-1].vld;
      if (pipe_q[T_CL-1].vld) Q <= pipe_q[T_CL-1].dat;
    end
  end

endmodule

// File: tb/tb_dram_model.sv
// Directed bench for dram_model: scoreboard of expected read returns checked on every cycle.
module tb_dram_model;

  localparam int T_CL = 5;

  logic        ACLK;
  logic        ARESETn;
  logic        CSn, RASn, CASn;
  logic [3:0]  WEn;
  logic [10:0] A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        valid, row_open, cmd_err;

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  dram_model dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .CSn      (CSn),
    .RASn     (RASn),
    .CASn     (CASn),
    .WEn      (WEn),
    .A        (A),
    .D        (D),
    .Q        (Q),
    .valid    (valid),
    .row_open (row_open),
    .cmd_err  (cmd_err)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge, then check any read return against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge ACLK);
    cyc++;
    #1;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rd_data", Q, e.dat);
        chk("rd_latency", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("missing_valid", 32'(valid), 32'd1);
    end
  endtask

  task automatic nop(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic csn, input logic rasn, input logic casn,
                       input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
    CSn = csn; RASn = rasn; CASn = casn; WEn = wen; A = a; D = d;
    tick();
    CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF;
  endtask

  task automatic act(input logic [10:0] row);
    drive(1'b0, 1'b0, 1'b1, 4'hF, row, 32'd0);
  endtask

  task automatic pre();
    drive(1'b0, 1'b0, 1'b1, 4'h0, 11'd0, 32'd0);
  endtask

  task automatic wr(input logic [10:0] col, input logic [31:0] d, input logic [3:0] wen);
    drive(1'b0, 1'b1, 1'b0, wen, col, d);
  endtask

  task automatic rd_cmd(input logic [10:0] col);
    drive(1'b0, 1'b1, 1'b0, 4'hF, col, 32'd0);
  endtask

  task automatic rd(input logic [10:0] col, input logic [31:0] exp);
    rd_cmd(col);
    sb.push_back('{dat: exp, due: cyc + T_CL});
  endtask

  initial begin
    ARESETn = 1'b0;
    CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0;
    nop(3);
    chk("reset_q", Q, 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_row_open", 32'(row_open), 32'd0);
    chk("reset_cmd_err", 32'(cmd_err), 32'd0);
    ARESETn = 1'b1;
    nop(1);

    // Activate row 0x012 and confirm row_open rises exactly tRCD-1 edges later
    act(11'h012);
    nop(3);
    chk("row_open_early", 32'(row_open), 32'd0);
    nop(1);
    chk("row_open_trcd", 32'(row_open), 32'd1);
    wr(11'h004, 32'hDEADBEEF, 4'h0);
    rd(11'h004, 32'hDEADBEEF);
    nop(T_CL + 1);
    chk("row_open_active", 32'(row_open), 32'd1);

    // Byte-lane write, then read-before-write ordering on the same word
    wr(11'h004, 32'h11223344, 4'b1010);
    rd(11'h004, 32'hDE22BE44);
    wr(11'h004, 32'hCAFEF00D, 4'h0);
    rd(11'h004, 32'hCAFEF00D);
    nop(T_CL + 1);

    // Back-to-back reads, Q holds last word
    for (int c = 0; c < 4; c++) wr(11'(c), 32'hA0 + 32'(c), 4'h0);
    for (int c = 0; c < 4; c++) rd(11'(c), 32'hA0 + 32'(c));
    nop(T_CL + 3);
    chk("q_hold", Q, 32'h000000A3);
    chk("no_err_yet", 32'(cmd_err), 32'd0);

    // PRE then ACT exactly tRP later; second row stays separate
    pre();
    nop(4);
    act(11'h055);
    chk("act_after_trp", 32'(cmd_err), 32'd0);
    nop(4);
    chk("row_open_row55", 32'(row_open), 32'd1);
    wr(11'h004, 32'h55555555, 4'h0);
    rd(11'h004, 32'h55555555);
    nop(T_CL + 1);

    // Read still in flight when PRE is issued
    rd(11'h004, 32'h55555555);
    pre();
    nop(T_CL + 1);
    chk("row_closed", 32'(row_open), 32'd0);
    act(11'h012);
    nop(4);
    rd(11'h004, 32'hCAFEF00D);
    rd(11'h000, 32'h000000A0);
    nop(T_CL + 1);
    chk("no_err_rows", 32'(cmd_err), 32'd0);

    // READ during tRCD is illegal; ACT while ACTIVE is ignored
    pre();
    nop(4);
    act(11'h012);
    nop(1);
    rd_cmd(11'h004);
    chk("err_rd_in_trcd", 32'(cmd_err), 32'd1);
    nop(2);
    act(11'h055);
    chk("err_act_active", 32'(cmd_err), 32'd1);
    rd(11'h004, 32'hCAFEF00D);
    nop(T_CL + 1);
    chk("err_sticky", 32'(cmd_err), 32'd1);

    // Reset mid-flight discards the pending return
    rd_cmd(11'h004);
    nop(2);
    ARESETn = 1'b0;
    #2;
    chk("rst_q", Q, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_row_open", 32'(row_open), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    nop(3);
    ARESETn = 1'b1;
    nop(T_CL + 2);
    chk("rst_q_after", Q, 32'd0);
    rd_cmd(11'h004);
    chk("err_rd_idle", 32'(cmd_err), 32'd1);
    nop(T_CL + 2);
    chk("q_after_idle_rd", Q, 32'd0);
    chk("idle_row_open", 32'(row_open), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
